// File: rtl/uart_rx_gen2_pkg.sv
// uart_rx_gen2_pkg: receiver state encoding, parity constants and the majority-vote helper
package uart_rx_gen2_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-FF synchroniser, per-bit edge counter and 3-sample majority bit decision
module uart_rx_sampler
   import uart_rx_gen2_pkg::*;
#(
   parameter int PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx_in,
   input  logic               clr,
   input  logic [PRESC_W-1:0] presc,
   output logic               rx_s,
   output logic               bit_val,
   output logic               dec_stb,
   output logic               end_stb
);
   logic rx_m;
   logic [PRESC_W-1:0] cnt, half;
   logic [2:0] smp;
   logic smp_en;
   assign half    = presc >> 1;
   assign smp_en  = cnt == half - PRESC_W'(1) || cnt == half || cnt == half + PRESC_W'(1);
   // the last sample lands at half+1, so the vote is only trustworthy one edge later
   assign dec_stb = !clr && cnt == half + PRESC_W'(2);
   assign end_stb = !clr && cnt == presc - PRESC_W'(1);
   assign bit_val = maj3(smp);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         cnt  <= '0;
         smp  <= '1;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
         cnt  <= (clr || end_stb) ? '0 : cnt + PRESC_W'(1);
         if (smp_en) smp <= {rx_s, smp[2:1]};
      end
endmodule

// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: parametrised UART receiver; frame FSM, parity/stop checks and a one-entry
// valid/ready output buffer with overrun detection
module uart_rx_gen2
   import uart_rx_gen2_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PRESC_W = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RX_IN,
   input  logic               PAR_EN,
   input  logic               PAR_TYP,
   input  logic               STOP2,
   input  logic [PRESC_W-1:0] Prescale,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  P_DATA,
   output logic               data_valid,
   output logic               Parity_error,
   output logic               Framing_error,
   output logic               Overrun_error
);
   state_t state, state_nx;
   logic [3:0] bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [PRESC_W-1:0] presc_l;
   logic par_en_l, par_typ_l, stop2_l, armed, par_err, frm_err;
   logic rx_s, bit_val, dec_stb, end_stb, start_go, last_data, last_stop, wr;

   uart_rx_sampler #(.PRESC_W(PRESC_W)) u_smp (
      .clk     (CLK),
      .rst_n   (RST),
      .rx_in   (RX_IN),
      .clr     (state == IDLE),
      .presc   (presc_l),
      .rx_s    (rx_s),
      .bit_val (bit_val),
      .dec_stb (dec_stb),
      .end_stb (end_stb)
   );

   // armed drops when a frame ends on a low line, so a held break is reported only once
   assign start_go  = state == IDLE && !rx_s && armed;
   assign last_data = bit_cnt == 4'(DATA_W - 1);
   assign last_stop = bit_cnt == {3'b000, stop2_l};
   assign wr        = state == DONE && (!data_valid || out_ready);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start_go) state_nx = START;
         START:   if (dec_stb && bit_val) state_nx = IDLE;
                  else if (end_stb) state_nx = DATA;
         DATA:    if (end_stb && last_data) state_nx = par_en_l ? PARITY : STOP;
         PARITY:  if (end_stb) state_nx = STOP;
         STOP:    if (dec_stb && last_stop) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST)
      if (!RST) state <= IDLE;
      else state <= state_nx;

   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         armed     <= 1'b1;
         bit_cnt   <= '0;
         shreg     <= '0;
         presc_l   <= '0;
         par_en_l  <= 1'b0;
         par_typ_l <= 1'b0;
         stop2_l   <= 1'b0;
         par_err   <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         armed   <= rx_s | (armed & state != DONE);
         bit_cnt <= (state_nx != state) ? '0 : bit_cnt + 4'(end_stb);
         if (start_go) begin
            presc_l   <= Prescale;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            stop2_l   <= STOP2;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
         end
         if (state == DATA && dec_stb) shreg <= {bit_val, shreg[DATA_W-1:1]};
         if (state == PARITY && dec_stb) par_err <= bit_val ^ (^shreg) ^ (par_typ_l == PAR_ODD);
         if (state == STOP && dec_stb && !bit_val) frm_err <= 1'b1;
      end

   // a frame completing while the buffer is full is dropped unless the consumer frees it that cycle
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         P_DATA        <= '0;
         data_valid    <= 1'b0;
         Parity_error  <= 1'b0;
         Framing_error <= 1'b0;
         Overrun_error <= 1'b0;
      end else begin
         if (wr) begin
            P_DATA        <= shreg;
            Parity_error  <= par_err;
            Framing_error <= frm_err;
         end
         data_valid    <= wr | (data_valid & !out_ready);
         Overrun_error <= state == DONE && !wr;
      end
endmodule

// File: tb/tb_uart_rx_gen2.sv
// tb_uart_rx_gen2: vector table, corner-case sequences and a random frame scoreboard
module tb_uart_rx_gen2;
   typedef struct packed {logic [7:0] d; logic pe; logic fe;} rec_t;
   typedef struct {
      logic [7:0] d; int p; logic pe, pt, s2, flip; logic [1:0] bs;
      logic [7:0] ed; logic epe, efe;
   } vec_t;

   logic CLK = 1'b0, RST, rx, sel7, out_ready, PAR_EN, PAR_TYP, STOP2, found;
   logic [5:0] Prescale;
   logic [7:0] P_DATA;
   logic [6:0] pd7;
   logic data_valid, Parity_error, Framing_error, Overrun_error, dv7, pe7, fe7, ov7;
   logic rx8_line, rx7_line, dv_q, rdy_q;
   int n_cmp = 0, n_bad = 0, dv_cnt = 0, ovr_cnt = 0;
   rec_t q[$], exp_q[$];
   logic [8:0] q7[$];
   vec_t tbl[9];

   assign rx8_line = sel7 ? 1'b1 : rx;
   assign rx7_line = sel7 ? rx : 1'b1;

   uart_rx_gen2 #(.DATA_W(8), .PRESC_W(6)) dut8 (
      .CLK(CLK), .RST(RST), .RX_IN(rx8_line), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .STOP2(STOP2), .Prescale(Prescale), .out_ready(out_ready), .P_DATA(P_DATA),
      .data_valid(data_valid), .Parity_error(Parity_error), .Framing_error(Framing_error),
      .Overrun_error(Overrun_error));

   uart_rx_gen2 #(.DATA_W(7), .PRESC_W(6)) dut7 (
      .CLK(CLK), .RST(RST), .RX_IN(rx7_line), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .STOP2(STOP2), .Prescale(Prescale), .out_ready(out_ready), .P_DATA(pd7),
      .data_valid(dv7), .Parity_error(pe7), .Framing_error(fe7), .Overrun_error(ov7));

   always #5 CLK = ~CLK;

   initial begin
      #900000;
      $display("FAIL watchdog: bench did not finish, got timeout want completion");
      $fatal(1);
   end

   // a buffered frame is new when the previous sample showed it empty or being consumed
   always @(negedge CLK) begin
      if (data_valid && (!dv_q || rdy_q)) q.push_back({P_DATA, Parity_error, Framing_error});
      if (data_valid) dv_cnt++;
      if (Overrun_error) ovr_cnt++;
      if (dv7) q7.push_back({pd7, pe7, fe7});
      dv_q  = data_valid;
      rdy_q = out_ready;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic hold(input logic b, input int n);
      rx = b;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input int w, input int p, input logic pe,
                             input logic pt, input logic s2, input logic flip,
                             input logic [1:0] bs, input int spike);
      logic [12:0] bits;
      logic par;
      int n;
      bits = '1;
      bits[0] = 1'b0;
      par = pt ^ flip;
      for (int i = 0; i < w; i++) begin
         bits[1+i] = d[i];
         par ^= d[i];
      end
      n = 1 + w;
      if (pe) begin
         bits[n] = par;
         n++;
      end
      bits[n] = !bs[0];
      n++;
      if (s2) begin
         bits[n] = !bs[1];
         n++;
      end
      PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Prescale = 6'(p);
      for (int i = 0; i < n; i++) begin
         if (i == spike) begin
            hold(bits[i], p / 2);
            hold(!bits[i], 1);
            hold(bits[i], p / 2 - 1);
         end else hold(bits[i], p);
         if (i == 0) begin
            PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
            STOP2 = 1'($urandom); Prescale = 6'($urandom);
         end
      end
      rx = 1'b1;
   endtask

   task automatic check_one(input string name, input rec_t e);
      rec_t r;
      chk({name, " count"}, 32'(q.size()), 1);
      if (q.size() > 0) begin
         r = q.pop_front();
         chk({name, " data"}, 32'(r.d), 32'(e.d));
         chk({name, " parity_err"}, 32'(r.pe), 32'(e.pe));
         chk({name, " framing_err"}, 32'(r.fe), 32'(e.fe));
      end
   endtask

   initial begin
      int base_ovr, base_dv, p, gap;
      logic [7:0] d;
      logic pe, pt, s2, flip;
      logic [1:0] bs;
      int spike;
      rec_t r;
      tbl[0] = '{8'hA5,  8, 0, 0, 0, 0, 2'b00, 8'hA5, 0, 0};
      tbl[1] = '{8'h3C, 16, 1, 0, 0, 0, 2'b00, 8'h3C, 0, 0};
      tbl[2] = '{8'h3C, 16, 1, 1, 0, 1, 2'b00, 8'h3C, 1, 0};
      tbl[3] = '{8'h00, 12, 1, 0, 0, 1, 2'b00, 8'h00, 1, 0};
      tbl[4] = '{8'hFF, 32, 0, 0, 1, 0, 2'b10, 8'hFF, 0, 1};
      tbl[5] = '{8'h3C, 32, 0, 0, 1, 0, 2'b00, 8'h3C, 0, 0};
      tbl[6] = '{8'h81,  8, 0, 0, 1, 0, 2'b01, 8'h81, 0, 1};
      tbl[7] = '{8'h96,  6, 0, 0, 0, 0, 2'b00, 8'h96, 0, 0};
      tbl[8] = '{8'hC3, 62, 1, 1, 0, 0, 2'b00, 8'hC3, 0, 0};
      RST = 1'b0; rx = 1'b1; sel7 = 1'b0; out_ready = 1'b1;
      PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 6'd8;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset P_DATA", 32'(P_DATA), 0);
      chk("reset data_valid", 32'(data_valid), 0);
      chk("reset Parity_error", 32'(Parity_error), 0);
      chk("reset Framing_error", 32'(Framing_error), 0);
      chk("reset Overrun_error", 32'(Overrun_error), 0);
      RST = 1'b1;
      hold(1'b1, 5);

      for (int i = 0; i < 9; i++) begin
         base_dv = dv_cnt;
         send_frame(tbl[i].d, 8, tbl[i].p, tbl[i].pe, tbl[i].pt, tbl[i].s2, tbl[i].flip, tbl[i].bs, -1);
         hold(1'b1, 3 * tbl[i].p);
         check_one($sformatf("tbl[%0d]", i), '{tbl[i].ed, tbl[i].epe, tbl[i].efe});
         chk($sformatf("tbl[%0d] valid cycles", i), 32'(dv_cnt - base_dv), 1);
      end

      sel7 = 1'b1;
      send_frame(8'h55, 7, 16, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, -1);
      hold(1'b1, 48);
      sel7 = 1'b0;
      chk("w7 count", 32'(q7.size()), 1);
      if (q7.size() > 0) chk("w7 frame", 32'(q7.pop_front()), 32'({7'h55, 1'b1, 1'b0}));

      PAR_EN = 1'b0; STOP2 = 1'b0; Prescale = 6'd8;
      hold(1'b0, 2);
      hold(1'b1, 40);
      chk("glitch no frame", 32'(q.size()), 0);
      chk("glitch state", 32'(dut8.state), 32'(uart_rx_gen2_pkg::IDLE));

      hold(1'b0, 12 * 8);
      hold(1'b1, 32);
      check_one("break", '{8'h00, 1'b0, 1'b1});
      send_frame(8'h5A, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1);
      hold(1'b1, 24);
      check_one("after break", '{8'h5A, 1'b0, 1'b0});

      send_frame(8'hFF, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4);
      hold(1'b1, 24);
      check_one("spike", '{8'hFF, 1'b0, 1'b0});

      out_ready = 1'b0;
      base_ovr = ovr_cnt;
      send_frame(8'h11, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1);
      hold(1'b1, 24);
      send_frame(8'h22, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1);
      hold(1'b1, 24);
      chk("ovr pulse", 32'(ovr_cnt - base_ovr), 1);
      chk("ovr P_DATA kept", 32'(P_DATA), 32'h11);
      chk("ovr data_valid", 32'(data_valid), 1);
      found = 1'b0;
      fork
         send_frame(8'h33, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1);
         for (int i = 0; i < 200 && !found; i++) begin
            @(posedge CLK);
            #1;
            if (dut8.state == uart_rx_gen2_pkg::DONE) begin
               out_ready = 1'b1;
               @(posedge CLK);
               #1;
               out_ready = 1'b0;
               found = 1'b1;
            end
         end
      join
      chk("replace DONE seen", 32'(found), 1);
      hold(1'b1, 4);
      chk("replace P_DATA", 32'(P_DATA), 32'h33);
      chk("replace data_valid", 32'(data_valid), 1);
      chk("replace no overrun", 32'(ovr_cnt - base_ovr), 1);
      out_ready = 1'b1;
      hold(1'b1, 3);
      chk("drain data_valid", 32'(data_valid), 0);
      chk("ovr queue", 32'(q.size()), 2);
      if (q.size() == 2) begin
         r = q.pop_front();
         chk("ovr first", 32'(r.d), 32'h11);
         r = q.pop_front();
         chk("ovr second", 32'(r.d), 32'h33);
      end
      q.delete();

      fork
         send_frame(8'h96, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1);
         begin
            hold(1'b0, 32);
            RST = 1'b0;
            #1;
            chk("midreset P_DATA", 32'(P_DATA), 0);
            chk("midreset data_valid", 32'(data_valid), 0);
            chk("midreset flags", 32'({Parity_error, Framing_error, Overrun_error}), 0);
         end
      join
      hold(1'b1, 4);
      RST = 1'b1;
      hold(1'b1, 8);
      chk("midreset no frame", 32'(q.size()), 0);
      send_frame(8'h69, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1);
      hold(1'b1, 24);
      check_one("after reset", '{8'h69, 1'b0, 1'b0});

      for (int k = 0; k < 40; k++) begin
         d = 8'($urandom);
         p = 2 * $urandom_range(4, 8);
         pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
         flip = pe && $urandom_range(0, 3) == 0;
         bs = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, s2 ? 3 : 1)) : 2'b00;
         spike = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : -1;
         exp_q.push_back('{d, flip, |bs});
         send_frame(d, 8, p, pe, pt, s2, flip, bs, spike);
         gap = (s2 ? bs[1] : bs[0]) ? 2 * p : $urandom_range(0, 3);
         hold(1'b1, gap);
      end
      hold(1'b1, 64);
      chk("rand count", 32'(q.size()), 32'(exp_q.size()));
      for (int k = 0; k < 40 && q.size() > 0 && exp_q.size() > 0; k++)
         chk($sformatf("rand frame %0d", k), 32'(q.pop_front()), 32'(exp_q.pop_front()));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
